seg7_cycle_monitor: RTL

- Receive-side checker for the rotating single-segment seven-segment animation.
- Watches an active-low seg7 bus and decodes which outer segment (a..f) is lit.
- Locks onto the a→b→c→d→e→f→a rotation, counts completed laps and flags sequence errors.
- Used on the board and in benches to verify the spinner driver without visual inspection.

---
 rtl/seg7_cycle_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg7_cycle_monitor.sv
// Receive-side checker for the rotating single-segment spinner on an active-low seg7 bus.
// Locks onto the a->b->c->d->e->f rotation, counts laps and flags sequence errors.
module seg7_cycle_monitor #(
  parameter int LOCK_N = 3,
  parameter int LAP_W  = 8,
  parameter int ERR_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [0:6]       seg7,
  output logic [2:0]       pos,
  output logic             pos_valid,
  output logic             locked,
  output logic [LAP_W-1:0] lap_count,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t             r_state;
  logic [2:0]         r_pos;
  logic               r_pos_valid;
  logic               r_locked;
  logic [LAP_W-1:0]   r_lap_count;
  logic               r_err_pulse;
  logic [ERR_W-1:0]   r_err_count;
  logic [2:0]         r_prev;
  logic               r_prev_valid;
  logic [2:0]         r_run;
  logic [2:0]         r_expected;

  logic               w_legal;
  logic [2:0]         w_p;
  logic [2:0]         w_succ_p;
  logic [2:0]         w_succ_prev;
  logic [2:0]         w_run_inc;

  // Exactly one of a..f low with g dark; any other code is illegal.
  always_comb begin
    w_legal = 1'b1;
    w_p     = 3'd0;
    case (seg7)
      7'b0111111: w_p = 3'd0;
      7'b1011111: w_p = 3'd1;
      7'b1101111: w_p = 3'd2;
      7'b1110111: w_p = 3'd3;
      7'b1111011: w_p = 3'd4;
      7'b1111101: w_p = 3'd5;
      default:    w_legal = 1'b0;
    endcase
  end

  assign w_succ_p    = (w_p == 3'd5)    ? 3'd0 : w_p + 3'd1;
  assign w_succ_prev = (r_prev == 3'd5) ? 3'd0 : r_prev + 3'd1;
  assign w_run_inc   = r_run + 3'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_pos        <= 3'd0;
      r_pos_valid  <= 1'b0;
      r_locked     <= 1'b0;
      r_lap_count  <= '0;
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
      r_prev       <= 3'd0;
      r_prev_valid <= 1'b0;
      r_run        <= 3'd0;
      r_expected   <= 3'd0;
    end else begin
      r_err_pulse <= 1'b0;
      if (sample_en) begin
        r_pos_valid <= w_legal;
        if (w_legal) begin
          r_pos        <= w_p;
          r_prev       <= w_p;
          r_prev_valid <= 1'b1;
        end else begin
          r_prev_valid <= 1'b0;
        end
        case (r_state)
          SEARCH: begin
            if (w_legal && r_prev_valid && (w_p == w_succ_prev)) begin
              if (w_run_inc == 3'(LOCK_N)) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_expected <= w_succ_p;
                r_run      <= 3'd0;
              end else begin
                r_run <= w_run_inc;
              end
            end else begin
              r_run <= 3'd0;
            end
          end
          LOCKED: begin
            if (w_legal && (w_p == r_expected)) begin
              r_expected <= w_succ_p;
              // A lap closes on each accepted return to segment a.
              if ((w_p == 3'd0) && (r_lap_count != {LAP_W{1'b1}}))
                r_lap_count <= r_lap_count + 1'b1;
            end else begin
              r_err_pulse <= 1'b1;
              if (r_err_count != {ERR_W{1'b1}})
                r_err_count <= r_err_count + 1'b1;
              r_state  <= SEARCH;
              r_locked <= 1'b0;
              r_run    <= 3'd0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign pos       = r_pos;
  assign pos_valid = r_pos_valid;
  assign locked    = r_locked;
  assign lap_count = r_lap_count;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
